// File: rtl/step_clock_ctrl.sv
// CPU clock-enable generator: RUN, SLOW (divided), single STEP on a debounced
// pushbutton, and HALT, selected by a synchronized 2-bit mode switch.
module step_clock_ctrl #(
    parameter int SLOW_FACTOR     = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    output logic        cpu_en,
    output logic        halted,
    output logic [15:0] step_count,
    output logic [2:0]  state_dbg
);

    localparam int DV_W = $clog2(SLOW_FACTOR);
    localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DV_W-1:0] DV_LAST = DV_W'(SLOW_FACTOR - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SLOW,
        ST_STEP_ARMED,
        ST_STEP_HELD,
        ST_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            en_nx;
    logic [1:0]      mode_s1;
    logic [1:0]      sync_mode;
    logic            btn_s1;
    logic            sync_btn;
    logic            db;
    logic [DC_W-1:0] dcnt;
    logic [DV_W-1:0] dv;
    logic [DV_W-1:0] dv_nx;

    // Synchronizers reset to HALT mode so the CPU stays stopped until the switch is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_s1   <= 2'b11;
            sync_mode <= 2'b11;
            btn_s1    <= 1'b0;
            sync_btn  <= 1'b0;
        end else begin
            mode_s1   <= mode;
            sync_mode <= mode_s1;
            btn_s1    <= step_btn;
            sync_btn  <= btn_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (sync_btn == db) begin
            dcnt <= '0;
        end else if (dcnt == DC_LAST) begin
            db   <= sync_btn;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DC_W'(1);
        end
    end

    // Entering step mode with the button already down lands in STEP_HELD, so a
    // held or stale press never produces a pulse; only a fresh press from ARMED does.
    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        dv_nx    = '0;
        unique case (sync_mode)
            2'b00: begin
                state_nx = ST_RUN;
                en_nx    = 1'b1;
            end
            2'b01: begin
                state_nx = ST_SLOW;
                if (state == ST_SLOW) begin
                    if (dv == DV_LAST) begin
                        en_nx = 1'b1;
                    end else begin
                        dv_nx = dv + DV_W'(1);
                    end
                end
            end
            2'b10: begin
                case (state)
                    ST_STEP_ARMED: begin
                        if (db) begin
                            state_nx = ST_STEP_HELD;
                            en_nx    = 1'b1;
                        end
                    end
                    ST_STEP_HELD: begin
                        if (!db) state_nx = ST_STEP_ARMED;
                    end
                    default: state_nx = db ? ST_STEP_HELD : ST_STEP_ARMED;
                endcase
            end
            default: state_nx = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HALT;
            cpu_en     <= 1'b0;
            halted     <= 1'b1;
            dv         <= '0;
            step_count <= '0;
        end else begin
            state      <= state_nx;
            cpu_en     <= en_nx;
            halted     <= (state_nx == ST_HALT);
            dv         <= dv_nx;
            step_count <= step_count + {15'd0, cpu_en};
        end
    end

    assign state_dbg = state;

endmodule
